acumulador_sat: RTL and testbench

Parametrised, mode-selectable successor to the sample-and-hold accumulator register in the datapath. It holds, tracks, free-run integrates or integrate-and-dumps a signed N-bit fixed-point stream with two's-complement saturation. It flags value changes and overflow, and adds a valid handshake and synchronous active-low reset. It sits between the sample source and the downstream control/filter stages that consume `Acumulado`.

---
 rtl/acumulador_sat_if.sv | 24 ++
 rtl/acumulador_sat.sv | 121 ++++++++++++
 tb/tb_acumulador_sat.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/acumulador_sat_if.sv
// Sample stream and result bundle between the sample source and acumulador_sat.
// The master drives samples and control, and the slave returns the accumulated result.
interface acumulador_sat_if #(
  parameter int N = 25
);
  logic         clear;
  logic [1:0]   mode;
  logic         in_valid;
  logic [N-1:0] In;
  logic [N-1:0] Acumulado;
  logic         out_valid;
  logic         changed;
  logic         sat;

  modport master (
    output clear, mode, in_valid, In,
    input  Acumulado, out_valid, changed, sat
  );

  modport slave (
    input  clear, mode, in_valid, In,
    output Acumulado, out_valid, changed, sat
  );
endinterface

// File: rtl/acumulador_sat.sv
// Mode-selectable saturating accumulator: hold, track, integrate-and-dump and free-run.
// Uses signed N-bit two's-complement data with a sticky overflow flag and a valid handshake.
module acumulador_sat #(
  parameter int N = 25,
  parameter int D = 4
) (
  input logic            clk,
  input logic            rst_n,
  acumulador_sat_if.slave bus
);
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
  localparam logic [N-1:0]  MAX_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MIN_VAL = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_TRACK = 2'b01,
    MODE_DUMP  = 2'b10,
    MODE_FREE  = 2'b11
  } mode_e;

  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [N-1:0]  acumulado_q, acumulado_d;
  logic          out_valid_q, out_valid_d;
  logic          changed_q, changed_d;
  logic          sat_q, sat_d;

  logic [N:0]    sum;
  logic [N-1:0]  sum_sat;
  logic          clamp;

  // The top two bits of the N+1 bit sum disagree only when the result is out of range.
  always_comb begin
    sum   = {acc_q[N-1], acc_q} + {bus.In[N-1], bus.In};
    clamp = sum[N] ^ sum[N-1];
    if (!clamp)
      sum_sat = sum[N-1:0];
    else if (sum[N])
      sum_sat = MIN_VAL;
    else
      sum_sat = MAX_VAL;
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    acumulado_d = acumulado_q;
    out_valid_d = 1'b0;
    changed_d   = 1'b0;
    sat_d       = sat_q;

    if (bus.clear) begin
      acc_d       = '0;
      cnt_d       = '0;
      mode_d      = bus.mode;
      acumulado_d = '0;
      sat_d       = 1'b0;
    end else if (bus.mode != mode_q) begin
      // Switching modes restarts accumulation but keeps the last published result.
      acc_d  = '0;
      cnt_d  = '0;
      mode_d = bus.mode;
    end else if (bus.in_valid) begin
      case (mode_e'(mode_q))
        MODE_TRACK: begin
          acumulado_d = bus.In;
          out_valid_d = 1'b1;
          changed_d   = (bus.In != acumulado_q);
        end
        MODE_DUMP: begin
          sat_d = sat_q | clamp;
          if (cnt_q == CNT_LAST) begin
            acumulado_d = sum_sat;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b1;
          end else begin
            acc_d = sum_sat;
            cnt_d = cnt_q + CW'(1);
          end
        end
        MODE_FREE: begin
          sat_d       = sat_q | clamp;
          acc_d       = sum_sat;
          acumulado_d = sum_sat;
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= bus.mode;
      acumulado_q <= '0;
      out_valid_q <= 1'b0;
      changed_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      acumulado_q <= acumulado_d;
      out_valid_q <= out_valid_d;
      changed_q   <= changed_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.Acumulado = acumulado_q;
  assign bus.out_valid = out_valid_q;
  assign bus.changed   = changed_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_acumulador_sat.sv
// Testbench for acumulador_sat with N=8 and D=4: directed scenarios, then a randomized run.
// The randomized run is checked against an integer model of the accumulator behaviour.
module tb_acumulador_sat;
  localparam int N = 8;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  acumulador_sat_if #(.N(N)) bus ();

  acumulador_sat #(.N(N), .D(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int exp_acc, exp_cnt, exp_mode, exp_out;
  bit exp_ov, exp_ch, exp_sat;

  function automatic int clamp8(input int s, inout bit flag);
    if (s > 127) begin flag = 1'b1; return 127; end
    if (s < -128) begin flag = 1'b1; return -128; end
    return s;
  endfunction

  // Drives one cycle of inputs, then advances the model to match the state after that edge.
  task automatic step(input logic r, input logic c, input logic [1:0] m,
                      input logic v, input logic [7:0] x);
    int xi;
    int s;
    rst_n        = r;
    bus.clear    = c;
    bus.mode     = m;
    bus.in_valid = v;
    bus.In       = x;
    @(posedge clk);
    #1;
    xi     = int'($signed(x));
    exp_ov = 1'b0;
    exp_ch = 1'b0;
    if (!r || c) begin
      exp_acc = 0; exp_cnt = 0; exp_out = 0; exp_sat = 1'b0;
      exp_mode = int'(m);
    end else if (int'(m) != exp_mode) begin
      exp_acc = 0; exp_cnt = 0; exp_mode = int'(m);
    end else if (v) begin
      case (m)
        2'b01: begin
          exp_ch  = (xi != exp_out);
          exp_out = xi;
          exp_ov  = 1'b1;
        end
        2'b10: begin
          s = clamp8(exp_acc + xi, exp_sat);
          if (exp_cnt == D - 1) begin
            exp_out = s; exp_acc = 0; exp_cnt = 0; exp_ov = 1'b1;
          end else begin
            exp_acc = s; exp_cnt = exp_cnt + 1;
          end
        end
        2'b11: begin
          s = clamp8(exp_acc + xi, exp_sat);
          exp_acc = s; exp_out = s; exp_ov = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 2'b11, 1'b1, 8'h55);
    step(1'b0, 1'b0, 2'b11, 1'b1, 8'h55);
    checks += 4;
    if (bus.Acumulado !== 8'd0) begin failures++; $display("[TB] FAIL reset_acumulado got=%0h want=0", bus.Acumulado); end
    if (bus.sat !== 1'b0) begin failures++; $display("[TB] FAIL reset_sat got=%b want=0", bus.sat); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    if (bus.changed !== 1'b0) begin failures++; $display("[TB] FAIL reset_changed got=%b want=0", bus.changed); end
  endtask

  task automatic test_track();
    logic [7:0] vals [3] = '{8'd5, 8'd5, 8'd7};
    logic       chg  [3] = '{1'b1, 1'b0, 1'b1};
    step(1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'b01, 1'b1, vals[i]);
      checks += 3;
      if (bus.Acumulado !== vals[i]) begin failures++; $display("[TB] FAIL track_acumulado[%0d] got=%0d want=%0d", i, bus.Acumulado, vals[i]); end
      if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL track_out_valid[%0d] got=%b want=1", i, bus.out_valid); end
      if (bus.changed !== chg[i]) begin failures++; $display("[TB] FAIL track_changed[%0d] got=%b want=%b", i, bus.changed, chg[i]); end
    end
    step(1'b1, 1'b0, 2'b01, 1'b0, 8'd99);
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL track_idle_out_valid got=%b want=0", bus.out_valid); end
    if (bus.Acumulado !== 8'd7) begin failures++; $display("[TB] FAIL track_idle_acumulado got=%0d want=7", bus.Acumulado); end
  endtask

  task automatic test_dump();
    step(1'b1, 1'b0, 2'b10, 1'b0, 8'd0);
    step(1'b1, 1'b0, 2'b10, 1'b1, 8'd10);
    step(1'b1, 1'b0, 2'b10, 1'b1, 8'd20);
    step(1'b1, 1'b0, 2'b10, 1'b0, 8'd77);
    step(1'b1, 1'b0, 2'b10, 1'b0, 8'd77);
    step(1'b1, 1'b0, 2'b10, 1'b1, 8'd30);
    checks += 1;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL dump_early_out_valid got=%b want=0", bus.out_valid); end
    step(1'b1, 1'b0, 2'b10, 1'b1, 8'd40);
    checks += 2;
    if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL dump_out_valid got=%b want=1", bus.out_valid); end
    if (bus.Acumulado !== 8'd100) begin failures++; $display("[TB] FAIL dump_acumulado got=%0d want=100", bus.Acumulado); end
    step(1'b1, 1'b0, 2'b10, 1'b0, 8'd0);
    checks += 1;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL dump_pulse_width got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    logic [7:0] vals [5] = '{8'd100, 8'd100, 8'h80, 8'h80, 8'h80};
    logic [7:0] want [5] = '{8'd100, 8'd127, 8'hFF, 8'h80, 8'h80};
    logic       wsat [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    step(1'b1, 1'b1, 2'b11, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 2'b11, 1'b1, vals[i]);
      checks += 2;
      if (bus.Acumulado !== want[i]) begin failures++; $display("[TB] FAIL sat_acumulado[%0d] got=%0h want=%0h", i, bus.Acumulado, want[i]); end
      if (bus.sat !== wsat[i]) begin failures++; $display("[TB] FAIL sat_flag[%0d] got=%b want=%b", i, bus.sat, wsat[i]); end
    end
    step(1'b1, 1'b1, 2'b11, 1'b0, 8'd0);
    checks += 1;
    if (bus.sat !== 1'b0) begin failures++; $display("[TB] FAIL sat_cleared got=%b want=0", bus.sat); end
  endtask

  task automatic test_mode_change();
    step(1'b1, 1'b1, 2'b10, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b10, 1'b1, 8'd1);
    step(1'b1, 1'b0, 2'b11, 1'b1, 8'd9);
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL modechg_out_valid got=%b want=0", bus.out_valid); end
    if (bus.Acumulado !== 8'd0) begin failures++; $display("[TB] FAIL modechg_hold_acumulado got=%0d want=0", bus.Acumulado); end
    step(1'b1, 1'b0, 2'b11, 1'b1, 8'd2);
    checks += 2;
    if (bus.Acumulado !== 8'd2) begin failures++; $display("[TB] FAIL modechg_acumulado got=%0d want=2", bus.Acumulado); end
    if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL modechg_next_out_valid got=%b want=1", bus.out_valid); end
  endtask

  task automatic test_clear_vs_valid();
    step(1'b1, 1'b0, 2'b11, 1'b1, 8'd7);
    step(1'b1, 1'b1, 2'b11, 1'b1, 8'd50);
    checks += 3;
    if (bus.Acumulado !== 8'd0) begin failures++; $display("[TB] FAIL clear_acumulado got=%0d want=0", bus.Acumulado); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clear_out_valid got=%b want=0", bus.out_valid); end
    if (bus.sat !== 1'b0) begin failures++; $display("[TB] FAIL clear_sat got=%b want=0", bus.sat); end
    step(1'b1, 1'b0, 2'b11, 1'b1, 8'd5);
    checks += 1;
    if (bus.Acumulado !== 8'd5) begin failures++; $display("[TB] FAIL clear_next_acumulado got=%0d want=5", bus.Acumulado); end
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [7:0] want;
    m = 2'b11;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) m = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 39) == 0), m,
           ($urandom_range(0, 3) != 0), 8'($urandom));
      want = 8'(exp_out);
      checks += 4;
      if (bus.Acumulado !== want) begin failures++; $display("[TB] FAIL rand_acumulado[%0d] got=%0h want=%0h", i, bus.Acumulado, want); end
      if (bus.out_valid !== exp_ov) begin failures++; $display("[TB] FAIL rand_out_valid[%0d] got=%b want=%b", i, bus.out_valid, exp_ov); end
      if (bus.changed !== exp_ch) begin failures++; $display("[TB] FAIL rand_changed[%0d] got=%b want=%b", i, bus.changed, exp_ch); end
      if (bus.sat !== exp_sat) begin failures++; $display("[TB] FAIL rand_sat[%0d] got=%b want=%b", i, bus.sat, exp_sat); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_acc = 0; exp_cnt = 0; exp_mode = 0; exp_out = 0;
    exp_ov = 1'b0; exp_ch = 1'b0; exp_sat = 1'b0;
    rst_n = 1'b0; bus.clear = 1'b0; bus.mode = 2'b00; bus.in_valid = 1'b0; bus.In = '0;
    test_reset();
    test_track();
    test_dump();
    test_saturation();
    test_mode_change();
    test_clear_vs_valid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
